// File: rtl/instruction_fetch_stage_if.sv
// Fetch-side bus: instruction memory read port plus the IF/ID register outputs.
// ifid_valid qualifies ifid_instr/ifid_pc_plus4 each cycle; there is no ready, the hazard unit's stall holds the register instead.
interface instruction_fetch_stage_if;
    logic [31:0] imem_pc;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;

    modport master (
        output imem_pc,
        input  imem_rdata,
        output ifid_instr,
        output ifid_pc_plus4,
        output ifid_valid
    );

    modport slave (
        input  imem_pc,
        output imem_rdata,
        input  ifid_instr,
        input  ifid_pc_plus4,
        input  ifid_valid
    );
endinterface

// File: rtl/instruction_fetch_stage.sv
// PC register, fetch control and IF/ID pipeline register for a 5-stage MIPS pipeline.
// Redirects beat stalls; a one-edge BOOT state lets the memory settle on RESET_PC.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 1024,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              stall,
    input  logic                              branch_taken,
    input  logic [31:0]                       branch_target,
    instruction_fetch_stage_if.master         fetch_bus,
    output logic                              pc_misaligned,
    output logic                              pc_out_of_range,
    output logic [31:0]                       fetch_count,
    output logic [31:0]                       stall_count,
    output logic                              dbg_state
);

    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;
    logic        misaligned_q, misaligned_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        pc_plus4_d   = pc_plus4_q;
        valid_d      = valid_q;
        misaligned_d = misaligned_q;
        fetch_cnt_d  = fetch_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (state_q == BOOT) begin
            state_d = RUN;
        end else if (branch_taken) begin
            pc_d    = {branch_target[31:2], 2'b00};
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            if (branch_target[1:0] != 2'b00) misaligned_d = 1'b1;
        end else if (stall) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            instr_d     = fetch_bus.imem_rdata;
            pc_plus4_d  = pc_q + 32'd4;
            valid_d     = 1'b1;
            pc_d        = pc_q + 32'd4;
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            instr_q      <= NOP_INSTR;
            pc_plus4_q   <= 32'd0;
            valid_q      <= 1'b0;
            misaligned_q <= 1'b0;
            fetch_cnt_q  <= 32'd0;
            stall_cnt_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pc_plus4_q   <= pc_plus4_d;
            valid_q      <= valid_d;
            misaligned_q <= misaligned_d;
            fetch_cnt_q  <= fetch_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    // Range flag only informs; fetch proceeds past the end of memory.
    assign pc_out_of_range         = {2'b00, pc_q[31:2]} >= 32'(IMEM_WORDS);
    assign fetch_bus.imem_pc       = pc_q;
    assign fetch_bus.ifid_instr    = instr_q;
    assign fetch_bus.ifid_pc_plus4 = pc_plus4_q;
    assign fetch_bus.ifid_valid    = valid_q;
    assign pc_misaligned           = misaligned_q;
    assign fetch_count             = fetch_cnt_q;
    assign stall_count             = stall_cnt_q;
    assign dbg_state               = state_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: behavioural memory, reference model feeding an
// expected-result queue, directed scenarios followed by random stall/redirect traffic.
module tb_instruction_fetch_stage;
  localparam int W = 97;  // {pc, valid, pc_plus4, instr}
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        pc_misaligned;
  logic        pc_out_of_range;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
  logic        dbg_state;

  instruction_fetch_stage_if bus ();

  instruction_fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (1024),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .fetch_bus       (bus.master),
    .pc_misaligned   (pc_misaligned),
    .pc_out_of_range (pc_out_of_range),
    .fetch_count     (fetch_count),
    .stall_count     (stall_count),
    .dbg_state       (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  assign bus.imem_rdata = mem[bus.imem_pc[11:2]];

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // reference model
  logic        m_run;
  logic [31:0] m_pc, m_instr, m_pc4, m_fetch, m_stall;
  logic        m_valid, m_mis;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_pc = 32'h0; m_instr = NOP; m_pc4 = 32'h0;
    m_valid = 1'b0; m_mis = 1'b0; m_fetch = 32'h0; m_stall = 32'h0;
    exp_q.delete();
  endtask

  task automatic check_reset_values();
    check_eq("rst_pc", bus.imem_pc, 32'h0);
    check_eq("rst_instr", bus.ifid_instr, NOP);
    check_eq("rst_pc4", bus.ifid_pc_plus4, 32'h0);
    check_eq("rst_valid", bus.ifid_valid, 1'b0);
    check_eq("rst_mis", pc_misaligned, 1'b0);
    check_eq("rst_fetch", fetch_count, 32'h0);
    check_eq("rst_stall", stall_count, 32'h0);
    check_eq("rst_state", dbg_state, 1'b0);
  endtask

  // Pulse reset between edges and check outputs react without a clock.
  task automatic pulse_reset();
    #3 rst_n = 1'b0;
    #1 check_reset_values();
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  // driver: apply one cycle of inputs, predict, then compare after the edge
  task automatic step(input logic s, input logic b, input logic [31:0] t);
    logic [W-1:0] e;
    stall = s; branch_taken = b; branch_target = t;
    if (!m_run) begin
      m_run = 1'b1;
    end else if (b) begin
      m_pc = {t[31:2], 2'b00}; m_instr = NOP; m_valid = 1'b0;
      if (t[1:0] != 2'b00) m_mis = 1'b1;
    end else if (s) begin
      m_stall = m_stall + 32'd1;
    end else begin
      m_instr = mem[m_pc[11:2]]; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
      m_pc = m_pc + 32'd4; m_fetch = m_fetch + 32'd1;
    end
    exp_q.push_back({m_pc, m_valid, m_pc4, m_instr});
    @(posedge clk);
    #1;
    check_eq("sb_nonempty", exp_q.size(), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq("pc", bus.imem_pc, e[96:65]);
      check_eq("valid", bus.ifid_valid, e[64]);
      check_eq("pc_plus4", bus.ifid_pc_plus4, e[63:32]);
      check_eq("instr", bus.ifid_instr, e[31:0]);
    end
    check_eq("fetch_count", fetch_count, m_fetch);
    check_eq("stall_count", stall_count, m_stall);
    check_eq("misaligned", pc_misaligned, m_mis);
    check_eq("state", dbg_state, m_run);
    check_eq("out_of_range", pc_out_of_range, (m_pc >> 2) >= 32'd1024);
    stall = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic run_until_pc(input logic [31:0] target);
    for (int i = 0; i < 64 && m_pc != target; i++) step(1'b0, 1'b0, 32'h0);
    check_eq("reach_pc", bus.imem_pc, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'h0109_5020;
    mem[1] = 32'hAC0A_0000;
    mem[2] = 32'h0149_5822;
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    model_reset();
    #12;
    check_reset_values();
    rst_n = 1'b1;

    // boot edge then three free-running fetches
    step(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
    check_eq("seq1_instr2", bus.ifid_instr, 32'h0149_5822);
    check_eq("seq1_fetch", fetch_count, 32'd3);

    // stall after the first fetch
    pulse_reset();
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    check_eq("seq2_pc_held", bus.imem_pc, 32'h4);
    check_eq("seq2_instr_held", bus.ifid_instr, 32'h0109_5020);
    check_eq("seq2_stalls", stall_count, 32'd2);
    step(1'b0, 1'b0, 32'h0);
    check_eq("seq2_release", bus.ifid_instr, 32'hAC0A_0000);
    check_eq("seq2_pc4", bus.ifid_pc_plus4, 32'h8);

    // redirect from 0x18 back to 0x10
    run_until_pc(32'h18);
    step(1'b0, 1'b1, 32'h10);
    check_eq("seq3_bubble", bus.ifid_valid, 1'b0);
    step(1'b0, 1'b0, 32'h0);
    check_eq("seq3_word4", bus.ifid_instr, mem[4]);
    check_eq("seq3_pc4", bus.ifid_pc_plus4, 32'h14);

    // redirect beats a simultaneous stall
    step(1'b1, 1'b1, 32'h8);
    check_eq("seq4_pc", bus.imem_pc, 32'h8);
    check_eq("seq4_stalls", stall_count, 32'd2);

    // misaligned target, sticky across fetches
    step(1'b0, 1'b1, 32'h6);
    check_eq("seq5_pc", bus.imem_pc, 32'h4);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
    check_eq("seq5_sticky", pc_misaligned, 1'b1);

    // asynchronous reset mid-run at pc 0x20, then restart
    run_until_pc(32'h20);
    pulse_reset();
    step(1'b1, 1'b1, 32'h40);
    step(1'b0, 1'b0, 32'h0);
    check_eq("seq6_restart", bus.ifid_instr, 32'h0109_5020);

    // range flag and PC wrap
    step(1'b0, 1'b1, 32'h0000_0FFC);
    check_eq("oor_low", pc_out_of_range, 1'b0);
    step(1'b0, 1'b0, 32'h0);
    check_eq("oor_high", pc_out_of_range, 1'b1);
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0);
    check_eq("wrap_pc", bus.imem_pc, 32'h0);
    check_eq("wrap_pc4", bus.ifid_pc_plus4, 32'h0);

    // random stall / redirect traffic
    for (int i = 0; i < 80; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 32'h1FFF));

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
